// File: rtl/button_reader.sv
// Synchronizes, debounces and edge-detects N active-low button inputs.
// Define BTN_LONGPRESS_EN to build the per-channel long-press detector.
module button_reader #(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 12000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_n,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_o,
  output logic [N-1:0] long
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_LONGPRESS_EN
  localparam int unsigned   LW        = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  if (N < 1 || N > 8) begin : g_bad_n
    $error("button_reader: N must be 1..8");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("button_reader: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("button_reader: LONG_CYCLES must be >= 1");
  end

  logic [N-1:0] meta_q, meta_d;
  logic [N-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = ~btn_n;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          s;

    assign s = sync_q[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Counter is compared against its last value before incrementing, so it never wraps.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        RELEASED: begin
          if (s) begin
            state_d = PRESS_WAIT;
            cnt_d   = CW'(1);
          end else begin
            cnt_d = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    always_comb begin
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        PRESS_WAIT: begin
          if (s && cnt_q == CNT_LAST) begin
            press_d = 1'b1;
            level_d = 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (!s && cnt_q == CNT_LAST) begin
            release_d = 1'b1;
            level_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign level[i]     = level_q;
    assign press[i]     = press_q;
    assign release_o[i] = release_q;

`ifdef BTN_LONGPRESS_EN
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          fired_q, fired_d;
    logic          long_q, long_d;

    // Counts while the debounced level is high, so bounces through RELEASE_WAIT keep the count.
    always_comb begin
      lcnt_d  = lcnt_q;
      fired_d = fired_q;
      long_d  = 1'b0;
      if (!level_q || release_d) begin
        lcnt_d  = '0;
        fired_d = 1'b0;
      end else if (!fired_q) begin
        if (lcnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lcnt_q  <= '0;
        fired_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        lcnt_q  <= lcnt_d;
        fired_q <= fired_d;
        long_q  <= long_d;
      end
    end

    assign long[i] = long_q;
`else
    assign long[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader: constant vector table, directed corner cases,
// and randomized stimulus against a run-length debounce reference model.
module tb_button_reader;

  localparam int unsigned N  = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned LC = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_n;
  logic [N-1:0] level, press, release_o, long;

  button_reader #(
    .N              (N),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .level    (level),
    .press    (press),
    .release_o(release_o),
    .long     (long)
  );

  always #5 clk = ~clk;

  int unsigned passes = 0;
  int unsigned total  = 0;

  // Reference model: s is ~btn_n delayed two edges; level flips once s has
  // disagreed with it for DB consecutive samples.
  bit           m_syn1 [N];
  bit           m_syn2 [N];
  bit           m_lvl  [N];
  int           m_run  [N];
  int           m_hold [N];
  logic [N-1:0] e_level, e_press, e_rel, e_long;

  typedef struct {
    logic         rst;
    logic [N-1:0] btn_n;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic model_edge();
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_syn1[c] = 1'b0;
        m_syn2[c] = 1'b0;
        m_lvl[c]  = 1'b0;
        m_run[c]  = 0;
        m_hold[c] = 0;
      end else begin
        bit s;
        bit was;
        s   = m_syn2[c];
        was = m_lvl[c];
        if (s != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_lvl[c] = s;
            m_run[c] = 0;
            if (s) e_press[c] = 1'b1;
            else   e_rel[c]   = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
        if (e_rel[c]) m_hold[c] = 0;
        else if (was) begin
          m_hold[c]++;
`ifdef BTN_LONGPRESS_EN
          if (m_hold[c] == LC) e_long[c] = 1'b1;
`endif
        end
        if (e_press[c]) m_hold[c] = 0;
        m_syn2[c] = m_syn1[c];
        m_syn1[c] = ~btn_n[c];
      end
      e_level[c] = m_lvl[c];
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".level"},   32'(level),     32'(e_level));
    chk({tag, ".press"},   32'(press),     32'(e_press));
    chk({tag, ".release"}, 32'(release_o), 32'(e_rel));
    chk({tag, ".long"},    32'(long),      32'(e_long));
  endtask

  task automatic add(input logic r, input logic [N-1:0] b, input logic [N-1:0] l,
                     input logic [N-1:0] p, input logic [N-1:0] rl);
    vec_t v;
    v.rst = r; v.btn_n = b; v.lvl = l; v.prs = p; v.rel = rl;
    tbl.push_back(v);
  endtask

  initial begin
    int ev;
    int stray;
    int first;
    int p_at;
    int l_at;
    int l_cnt;
    int hold_left [N];

    rst   = 1'b1;
    btn_n = '1;

    // Press/release of channel 0, then a 3-cycle glitch; channel 1 idle.
    add(1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 2'b11, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 5; k++) add(0, 2'b10, 2'b00, 2'b00, 2'b00);
    add(0, 2'b10, 2'b01, 2'b01, 2'b00);
    add(0, 2'b10, 2'b01, 2'b00, 2'b00);
    for (int k = 0; k < 5; k++) add(0, 2'b11, 2'b01, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 2'b00, 2'b01);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) add(0, 2'b10, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 6; k++) add(0, 2'b11, 2'b00, 2'b00, 2'b00);

    for (int v = 0; v < tbl.size(); v++) begin
      rst   = tbl[v].rst;
      btn_n = tbl[v].btn_n;
      step($sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d.k_level", v),   32'(level),     32'(tbl[v].lvl));
      chk($sformatf("tbl%0d.k_press", v),   32'(press),     32'(tbl[v].prs));
      chk($sformatf("tbl%0d.k_release", v), 32'(release_o), 32'(tbl[v].rel));
    end

    // Bounce while pressed: no events, level stays high.
    btn_n = 2'b10;
    for (int k = 0; k < 8; k++) step("bounce_pre");
    ev = 0;
    for (int k = 0; k < 10; k++) begin
      btn_n[0] = (k % 2 == 0);
      step("bounce");
      ev += int'(press[0]) + int'(release_o[0]);
    end
    btn_n = 2'b10;
    for (int k = 0; k < 8; k++) begin
      step("bounce_post");
      ev += int'(press[0]) + int'(release_o[0]);
    end
    chk("bounce_events", 32'(ev), 32'd0);
    chk("bounce_level", 32'(level[0]), 32'd1);

    // Simultaneous release of both channels.
    btn_n = 2'b00;
    for (int k = 0; k < 8; k++) step("both_hold");
    chk("both_held_level", 32'(level), 32'h3);
    btn_n = 2'b11;
    stray = 0;
    for (int k = 1; k <= 8; k++) begin
      step("both_rel");
      if (k == 6) begin
        chk("both_release", 32'(release_o), 32'h3);
        chk("both_release_level", 32'(level), 32'h0);
      end else if (release_o != '0) stray++;
    end
    chk("both_release_stray", 32'(stray), 32'd0);

    // Reset in the middle of PRESS_WAIT, button held through it.
    btn_n = 2'b10;
    for (int k = 0; k < 5; k++) step("rst_pre");
    rst = 1'b1;
    step("rst_mid");
    chk("rst_outputs", 32'({level, press, release_o, long}), 32'd0);
    rst   = 1'b0;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      step("rst_post");
      if (press[0] && first < 0) first = k;
    end
    chk("rst_press_delay", 32'(first), 32'd6);

    // Long press from a fresh press.
    btn_n = 2'b11;
    for (int k = 0; k < 10; k++) step("long_rel");
    btn_n = 2'b10;
    p_at  = -1;
    l_at  = -1;
    l_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      step("long_hold");
      if (press[0]) p_at = k;
      if (long[0]) begin
        l_cnt++;
        l_at = k;
      end
    end
`ifdef BTN_LONGPRESS_EN
    chk("long_count", 32'(l_cnt), 32'd1);
    chk("long_offset", 32'(l_at - p_at), 32'(LC));
`else
    chk("long_count", 32'(l_cnt), 32'd0);
    chk("long_press_seen", 32'(p_at), 32'd6);
`endif

    // Randomized hold lengths around the debounce threshold, occasional reset.
    for (int c = 0; c < N; c++) hold_left[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        if (hold_left[c] == 0) begin
          btn_n[c]     = 1'($urandom_range(0, 1));
          hold_left[c] = $urandom_range(1, 9);
        end
        hold_left[c]--;
      end
      rst = ($urandom_range(0, 299) == 0);
      step("rand");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/button_reader.md
# button_reader

Input-side counterpart to the board's LED drivers: samples N raw, active-low push-button/PMOD switch inputs of the iCEstick, synchronizes them to the 12 MHz system clock, debounces each channel independently, and presents a clean level plus single-cycle press/release (and optionally long-press) event pulses. It sits between the top-level pins and any user logic, such as LED patterns or counters, that consumes button events.

## Interface
- N, default 4, number of independent button channels (1..8)
- DEBOUNCE_CYCLES, default 120000, consecutive stable samples required to accept a change (10 ms at 12 MHz); ≥2
- LONG_CYCLES, default 12000000, cycles held in PRESSED before long-press fires (1 s); ≥1; used only with BTN_LONGPRESS_EN
- clk  input  1  system clock, 12 MHz
- rst  input  1  synchronous, active-high reset
- btn_n  input  N  raw pin levels, active-low (0 = pressed), asynchronous to clk
- level  output  N  debounced state, 1 = pressed
- press  output  N  one-cycle pulse on accepted press
- release  output  N  one-cycle pulse on accepted release
- long  output  N  one-cycle pulse on long press (tied 0 without BTN_LONGPRESS_EN)

## Operation
- Per channel: 2-flop synchronizer on ~btn_n gives s[i] (1 = pressed). Synchronizer flops reset to 0 (released).
- Per-channel FSM, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; counter cnt, width $clog2(DEBOUNCE_CYCLES+1).
- RELEASED: s=1 → PRESS_WAIT, cnt←1. Else stay, cnt←0.
- PRESS_WAIT: s=0 → RELEASED, cnt←0 (glitch rejected, no pulse). s=1 and cnt==DEBOUNCE_CYCLES-1 → PRESSED, press←1, level←1. Else cnt←cnt+1.
- PRESSED: s=0 → RELEASE_WAIT, cnt←1. Else stay.
- RELEASE_WAIT: s=1 → PRESSED, cnt←0 (no pulse). s=0 and cnt==DEBOUNCE_CYCLES-1 → RELEASED, release←1, level←0. Else cnt←cnt+1.
- level changes only on the cycle of an accepted transition; never toggles during *_WAIT.
- press, release, long are registered, high for exactly one cycle per event; press and release never high together on one channel.
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
- Counters saturate by construction (compare before increment); no wrap-around.
- Reset (any cycle, including mid-debounce or mid-long-count): all FSMs → RELEASED, all counters 0, synchronizer flops 0, level/press/release/long = 0. A button held through reset is re-debounced and produces a fresh press.

## Timing
- Synchronizer latency: 2 cycles from the first edge sampling a new btn_n value to s.
- Press latency: raw 1→0 sampled at edge k with stable input after that → press and level high after edge k+1+DEBOUNCE_CYCLES; press low again after the following edge.
- Release latency is symmetric.
- Minimum accepted pulse or gap on btn_n: DEBOUNCE_CYCLES cycles. Anything shorter produces no event.
- Long press: fires LONG_CYCLES cycles after entering PRESSED while continuously in PRESSED; at most once per press. Bouncing into RELEASE_WAIT and back does not restart the long counter. An accepted release clears it.

## Configuration
- BTN_LONGPRESS_EN defined: per-channel long counter (width $clog2(LONG_CYCLES+1)) and a fired flag are built. long pulses as described.
- Not defined: no long counter or flag is synthesized. long is driven constant 0. All other behaviour is identical.

## Test plan
- Set N=2, DEBOUNCE_CYCLES=4. Drive btn_n[0] from 1 to 0 at edge 10 and hold → press[0] high only in the cycle after edge 15, level[0]=1 from then on, and channel 1 stays silent.
- Glitch: btn_n[0]=0 for 3 cycles, then 1 → no press, level[0] stays 0, FSM returns to RELEASED.
- Bounce: press accepted, then btn_n[0] toggles 0/1 every cycle for 10 cycles, then stable 0 → no release or extra press pulses, level[0] stays 1.
- Release both channels in the same cycle after both are held → release[1:0]=2'b11 for exactly one cycle, 5 cycles after the raw edge, and level=2'b00.
- Assert rst for 1 cycle when PRESS_WAIT cnt=3 → all outputs 0 next cycle. With btn_n held low, press fires DEBOUNCE_CYCLES+2 cycles after rst deasserts.
- With BTN_LONGPRESS_EN and LONG_CYCLES=8: hold 20 cycles past press → long[0] pulses once, 8 cycles after press. Without the macro, long stays 0.
